// File: rtl/rvga_membus_arbiter_pkg.sv
// Shared types for the single-port membus arbiter: FSM states, bus owner
// encoding and the starve counter width helper.
package rvga_membus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } rvga_arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } rvga_arb_owner_e;

  // Counter must hold 0..limit; a limit of 0 still needs one bit.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rvga_membus_arbiter_if.sv
// Requester-side cachebus pair plus the shared membus master port.
// slave = arbiter view, master = the core/memory environment view.
interface rvga_membus_arbiter_if #(parameter int word_width = 32);
  logic [word_width-1:0] i_addr_i, i_rdata_o;
  logic                  i_read_i, i_resp_o;
  logic [word_width-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic                  d_read_i, d_write_i, d_resp_o;
  logic [word_width-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic                  mem_read_o, mem_write_o, mem_resp_i;
  logic                  busy_o, owner_o;

  modport slave (
    input  i_addr_i, i_read_i, d_addr_i, d_read_i, d_write_i, d_wdata_i,
           mem_rdata_i, mem_resp_i,
    output i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
           mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o, busy_o, owner_o
  );

  modport master (
    output i_addr_i, i_read_i, d_addr_i, d_read_i, d_write_i, d_wdata_i,
           mem_rdata_i, mem_resp_i,
    input  i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
           mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o, busy_o, owner_o
  );
endinterface

// File: rtl/rvga_membus_arbiter.sv
// One-at-a-time membus arbiter: data side has priority, instruction side wins
// after starve_limit consecutive data grants while it waits.
module rvga_membus_arbiter
  import rvga_membus_arbiter_pkg::*;
#(
  parameter int word_width   = 32,
  parameter int starve_limit = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rvga_membus_arbiter_if.slave bus
);

  localparam int CNT_W = starve_cnt_width(starve_limit);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(starve_limit);

  rvga_arb_state_e       state_q, state_d;
  rvga_arb_owner_e       owner_q;
  logic [CNT_W-1:0]      starve_q;
  logic [word_width-1:0] addr_q, wdata_q;
  logic                  read_q, write_q;
  logic                  d_req, i_req, starve_hit, grant_i, grant_d, done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    d_req      = bus.d_read_i | bus.d_write_i;
    i_req      = bus.i_read_i;
    starve_hit = (starve_limit != 0) && (starve_q == STARVE_MAX);
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    state_d    = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req && (!d_req || starve_hit)) begin
          grant_i = 1'b1;
          state_d = ARB_BUSY_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = ARB_BUSY_D;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.mem_resp_i) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Address/wdata are left as-is on completion; only the strobes drop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      owner_q <= ARB_OWNER_I;
    end else if (grant_i) begin
      addr_q  <= bus.i_addr_i;
      read_q  <= 1'b1;
      write_q <= 1'b0;
      owner_q <= ARB_OWNER_I;
    end else if (grant_d) begin
      addr_q  <= bus.d_addr_i;
      wdata_q <= bus.d_wdata_i;
      read_q  <= bus.d_read_i & ~bus.d_write_i;
      write_q <= bus.d_write_i;
      owner_q <= ARB_OWNER_D;
    end else if (done) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   starve_q <= '0;
    else if (grant_i)                            starve_q <= '0;
    else if (grant_d && i_req) begin
      if (starve_q != STARVE_MAX)                starve_q <= starve_q + 1'b1;
    end else if (state_q == ARB_IDLE && !i_req)  starve_q <= '0;
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_read_o  = read_q;
  assign bus.mem_write_o = write_q;
  assign bus.busy_o      = (state_q != ARB_IDLE);
  assign bus.owner_o     = owner_q;

  assign bus.i_resp_o  = (state_q == ARB_BUSY_I) && bus.mem_resp_i;
  assign bus.d_resp_o  = (state_q == ARB_BUSY_D) && bus.mem_resp_i;
  assign bus.i_rdata_o = bus.i_resp_o ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o = bus.d_resp_o ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Directed plus randomized bench for rvga_membus_arbiter against a
// transaction-level model of the arbitration rules.
module tb_rvga_membus_arbiter;
  localparam int W   = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvga_membus_arbiter_if #(.word_width(W)) bus();

  rvga_membus_arbiter #(.word_width(W), .starve_limit(LIM)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: m_st 0 = idle, 1 = serving I, 2 = serving D
  int         m_st;
  logic [W-1:0] m_addr, m_wdata;
  logic       m_rd, m_wr, m_own;
  int         m_starve;
  int         lat = 0;
  bit         i_pend = 0, d_pend = 0, prev_ir = 0, prev_dr = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0; m_own = 0; m_starve = 0;
  endtask

  task automatic model_edge();
    bit dreq, ireq;
    dreq = bus.d_read_i | bus.d_write_i;
    ireq = bus.i_read_i;
    if (m_st == 0) begin
      if (ireq && (!dreq || (LIM != 0 && m_starve == LIM))) begin
        m_st = 1; m_addr = bus.i_addr_i; m_rd = 1; m_wr = 0; m_own = 0; m_starve = 0;
        lat = $urandom_range(0, 3);
      end else begin
        if (dreq) begin
          m_st = 2; m_addr = bus.d_addr_i; m_wdata = bus.d_wdata_i;
          m_wr = bus.d_write_i; m_rd = bus.d_read_i && !bus.d_write_i; m_own = 1;
          lat = $urandom_range(0, 3);
        end
        if (!ireq) m_starve = 0;
        else if (dreq && m_starve < LIM) m_starve++;
      end
    end else if (bus.mem_resp_i) begin
      m_st = 0; m_rd = 0; m_wr = 0;
    end
  endtask

  // compare DUT against the model a little after inputs have been applied
  task automatic settle();
    logic ir, dr;
    #1;
    ir = (m_st == 1) && bus.mem_resp_i;
    dr = (m_st == 2) && bus.mem_resp_i;
    chk("mem_addr",  bus.mem_addr_o,  m_addr);
    chk("mem_read",  bus.mem_read_o,  m_rd);
    chk("mem_write", bus.mem_write_o, m_wr);
    chk("busy",      bus.busy_o,      m_st != 0);
    chk("owner",     bus.owner_o,     m_own);
    chk("i_resp",    bus.i_resp_o,    ir);
    chk("d_resp",    bus.d_resp_o,    dr);
    chk("i_rdata",   bus.i_rdata_o,   ir ? bus.mem_rdata_i : '0);
    chk("d_rdata",   bus.d_rdata_o,   dr ? bus.mem_rdata_i : '0);
    if (m_wr) chk("mem_wdata", bus.mem_wdata_o, m_wdata);
    prev_ir = ir;
    prev_dr = dr;
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
  endtask

  task automatic rnd_cycle();
    logic [1:0] r;
    if (rst) rst = 1'b0;
    else if ($urandom_range(0, 199) == 0) begin
      rst = 1'b1; model_reset(); i_pend = 0; d_pend = 0;
    end
    if (prev_ir) i_pend = 0;
    if (prev_dr) d_pend = 0;
    if (!i_pend) begin
      bus.i_read_i = 1'($urandom_range(0, 1));
      bus.i_addr_i = $urandom;
      i_pend = bus.i_read_i;
    end else if (m_st == 1 && $urandom_range(0, 7) == 0) bus.i_read_i = 1'b0;
    if (!d_pend) begin
      r = 2'($urandom_range(0, 3));
      bus.d_read_i  = r[0];
      bus.d_write_i = r[1];
      bus.d_addr_i  = $urandom;
      bus.d_wdata_i = $urandom;
      d_pend = r[0] | r[1];
    end else if (m_st == 2 && $urandom_range(0, 7) == 0) begin
      bus.d_read_i = 1'b0; bus.d_write_i = 1'b0;
    end
    if (m_st != 0) begin
      if (lat == 0) bus.mem_resp_i = 1'b1;
      else begin bus.mem_resp_i = 1'b0; lat--; end
    end else bus.mem_resp_i = ($urandom_range(0, 7) == 0);
    bus.mem_rdata_i = $urandom;
    settle();
    adv();
  endtask

  initial begin
    logic [0:9] own_seq;
    own_seq = 10'b1111011110;   // D D D D I D D D D I
    bus.i_addr_i = 32'h100; bus.i_read_i = 1'b1;
    bus.d_addr_i = '0; bus.d_read_i = 1'b0; bus.d_write_i = 1'b0; bus.d_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_resp_i = 1'b0;
    model_reset();

    // 1: reset with I pending, then I read with 3-cycle memory latency
    @(negedge clk);
    settle();
    chk("t1_rst_read", bus.mem_read_o, 1'b0);
    chk("t1_rst_addr", bus.mem_addr_o, 32'h0);
    adv();
    rst = 1'b0;
    settle(); adv();
    settle();
    chk("t1_read",  bus.mem_read_o, 1'b1);
    chk("t1_addr",  bus.mem_addr_o, 32'h100);
    chk("t1_owner", bus.owner_o,    1'b0);
    adv();
    settle(); adv();
    bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    settle();
    chk("t1_iresp",  bus.i_resp_o,  1'b1);
    chk("t1_irdata", bus.i_rdata_o, 32'hDEADBEEF);
    chk("t1_dresp",  bus.d_resp_o,  1'b0);
    adv();

    // 2: simultaneous I read and D write, D first
    bus.mem_resp_i = 1'b0;
    bus.i_read_i = 1'b1; bus.i_addr_i = 32'h300;
    bus.d_write_i = 1'b1; bus.d_addr_i = 32'h200; bus.d_wdata_i = 32'h55;
    settle(); adv();
    settle();
    chk("t2_write", bus.mem_write_o, 1'b1);
    chk("t2_wdata", bus.mem_wdata_o, 32'h55);
    chk("t2_owner", bus.owner_o,     1'b1);
    bus.mem_resp_i = 1'b1;
    settle();
    chk("t2_dresp", bus.d_resp_o, 1'b1);
    adv();
    bus.mem_resp_i = 1'b0; bus.d_write_i = 1'b0;
    settle();
    chk("t2_gap_busy", bus.busy_o, 1'b0);
    adv();
    settle();
    chk("t2_i_owner", bus.owner_o,    1'b0);
    chk("t2_i_addr",  bus.mem_addr_o, 32'h300);
    bus.mem_resp_i = 1'b1;
    settle(); adv();

    // 3: both sides requesting continuously
    bus.d_read_i = 1'b1; bus.d_addr_i = 32'h400;
    for (int k = 0; k < 10; k++) begin
      bus.mem_resp_i = 1'b0;
      settle(); adv();
      chk("t3_owner", bus.owner_o, own_seq[k]);
      bus.mem_resp_i = 1'b1;
      settle(); adv();
    end
    bus.i_read_i = 1'b0; bus.d_read_i = 1'b0; bus.mem_resp_i = 1'b0;
    settle(); adv();

    // 4: reset in the middle of a D transaction
    bus.d_read_i = 1'b1; bus.d_addr_i = 32'h80;
    settle(); adv();
    settle(); adv();
    rst = 1'b1; model_reset(); bus.d_read_i = 1'b0;
    settle();
    chk("t4_busy", bus.busy_o,     1'b0);
    chk("t4_read", bus.mem_read_o, 1'b0);
    chk("t4_addr", bus.mem_addr_o, 32'h0);
    adv();
    rst = 1'b0; bus.mem_resp_i = 1'b1;
    settle();
    chk("t4_dresp", bus.d_resp_o, 1'b0);
    adv();
    bus.mem_resp_i = 1'b0;

    // 5: read+write together, request withdrawn mid-transaction
    bus.d_read_i = 1'b1; bus.d_write_i = 1'b1; bus.d_addr_i = 32'h40; bus.d_wdata_i = 32'h77;
    settle(); adv();
    chk("t5_write", bus.mem_write_o, 1'b1);
    chk("t5_read",  bus.mem_read_o,  1'b0);
    bus.d_read_i = 1'b0; bus.d_write_i = 1'b0;
    settle(); adv();
    bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'h1234;
    settle();
    chk("t5_dresp",  bus.d_resp_o,  1'b1);
    chk("t5_drdata", bus.d_rdata_o, 32'h1234);
    adv();

    // 6: stray memory response while idle
    settle();
    chk("t6_iresp", bus.i_resp_o, 1'b0);
    chk("t6_dresp", bus.d_resp_o, 1'b0);
    adv();
    bus.mem_resp_i = 1'b0;
    settle();
    chk("t6_busy", bus.busy_o, 1'b0);
    adv();

    // randomized traffic with occasional resets
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 4000; c++) rnd_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rvga_membus_arbiter.md
Name: rvga_membus_arbiter

Overview:
Shares one external memory bus between the instruction-side and data-side cache buses when the core is built for a single memory port. It sits between the ifetch/memory-stage cachebus signals (or the L1 miss ports) and the one membus master port. It runs one transaction at a time, with data-side priority and a bounded-starvation rule for instruction fetch. Memory-side outputs are registered.

Parameters:
word_width, 32, width of address, rdata and wdata.
starve_limit, 4, number of consecutive data grants while an instruction request is pending before the instruction request wins; 0 gives strict data priority.

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous active-high reset
i_addr_i  input  word_width  instruction request address
i_read_i  input  1  instruction read request, level, held until i_resp_o
i_rdata_o  output  word_width  instruction read data, valid with i_resp_o
i_resp_o  output  1  instruction completion pulse
d_addr_i  input  word_width  data request address
d_read_i  input  1  data read request, level
d_write_i  input  1  data write request, level
d_wdata_i  input  word_width  data write data
d_rdata_o  output  word_width  data read data, valid with d_resp_o
d_resp_o  output  1  data completion pulse
mem_addr_o  output  word_width  membus address (registered)
mem_read_o  output  1  membus read (registered)
mem_write_o  output  1  membus write (registered)
mem_wdata_o  output  word_width  membus write data (registered)
mem_rdata_i  input  word_width  membus read data
mem_resp_i  input  1  membus completion
busy_o  output  1  transaction outstanding
owner_o  output  1  0 = instruction side, 1 = data side; valid while busy_o

Behaviour:
- Reset (async, any state, including mid-transaction): state IDLE, all mem_* outputs 0, busy_o 0, owner_o 0, starve counter 0. Any in-flight transaction is abandoned and no resp is issued.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated every cycle:
  - d_req = d_read_i | d_write_i; i_req = i_read_i.
  - Grant I when i_req & (~d_req | (starve_limit != 0 & starve_cnt == starve_limit)).
  - Otherwise grant D when d_req.
- On grant, at the same clock edge:
  - Register the winner's addr, wdata, read and write onto mem_*_o.
  - Set busy_o and owner_o; move to BUSY_I or BUSY_D.
  - Request-to-bus latency is 1 cycle.
- If d_read_i and d_write_i are both set: the write is issued and the read is dropped (mem_read_o 0).
- BUSY_x:
  - mem_* outputs and owner_o hold their values.
  - Requester inputs are ignored; a withdrawn request still completes and still gets its resp.
  - When mem_resp_i is 1: x_resp_o = 1 and x_rdata_o = mem_rdata_i, combinationally in that cycle, for the owner only. The other side's resp stays 0.
  - Next edge: state IDLE, mem_read_o/mem_write_o/busy_o cleared. mem_addr_o and mem_wdata_o keep their last values.
- The IDLE gap cycle is mandatory. Requesters must update their request in the cycle after resp; the arbiter samples it in IDLE.
- A mem_resp_i seen in IDLE is ignored; no resp output.
- i_rdata_o and d_rdata_o are 0 whenever their resp is 0.
- Starve counter:
  - Increments, saturating at starve_limit, on each D grant made while i_req = 1.
  - Clears on an I grant, or in IDLE when i_req = 0.
  - Width is clog2(starve_limit+1), minimum 1.
- Throughput: one transaction per (mem latency + 2) cycles.

Decomposition:
- rvga_types gets:
  - enum rvga_arb_state_e {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}
  - enum rvga_arb_owner_e {ARB_OWNER_I = 0, ARB_OWNER_D = 1}
- No sub-module: FSM, starve counter and output registers stay in one module.
- rvga_top instantiates the arbiter in place of the two independent membus connections when a single-port build is selected.

Test Plan:
1. Reset with i_read_i=1, i_addr_i=0x100 → all mem_* outputs 0; after deassert, next edge gives mem_read_o=1, mem_addr_o=0x100, owner_o=0. mem_resp_i=1 with rdata 0xDEADBEEF after 3 cycles → i_resp_o=1 and i_rdata_o=0xDEADBEEF for 1 cycle, d_resp_o=0.
2. I read and D write (addr 0x200, wdata 0x55) raised in the same cycle → D granted first with mem_write_o=1 and mem_wdata_o=0x55; I granted after D's resp plus the 1-cycle IDLE gap.
3. starve_limit=4, D and I both requesting continuously → grant order D,D,D,D,I,D,D,D,D,I; counter resets after each I grant.
4. Assert rst_i two cycles into a BUSY_D transaction → outputs 0 immediately; a later mem_resp_i produces no d_resp_o.
5. d_read_i=d_write_i=1, addr 0x40 → mem_write_o=1, mem_read_o=0; D drops its request mid-transaction → d_resp_o still pulses on mem_resp_i.
6. mem_resp_i=1 while IDLE with no requests → no resp outputs, state stays IDLE, busy_o=0.
